// File: rtl/systempll_lock_monitor_pkg.sv
// Shared definitions for the system PLL lock monitor.
//   ch_state_e : per-channel supervision state (2-bit encoding)
//   cnt_width  : bits needed for a counter that runs 0 .. max_count-1
package systempll_lock_monitor_pkg;

  typedef enum logic [1:0] {
    CH_DISABLED  = 2'd0,
    CH_WAIT_LOCK = 2'd1,
    CH_SETTLE    = 2'd2,
    CH_LOCKED    = 2'd3
  } ch_state_e;

  // Counter width for values 0 .. max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    if (max_count <= 2) begin
      cnt_width = 1;
    end else begin
      cnt_width = $clog2(max_count);
    end
  endfunction

endpackage

// File: rtl/systempll_lock_monitor_if.sv
// Bus bundle between the lock monitor and its environment.
//   master : drives in_synthlock, disable_monitor, clear_sticky; observes status
//   slave  : the monitor itself; consumes controls, drives status
//   in_synthlock    [N_CH]            raw PLL lock bits, asynchronous to clk
//   disable_monitor [N_CH]            per-channel supervision disable
//   clear_sticky                      one-cycle clear of sticky flags / loss counters
//   ch_locked       [N_CH]            channel declared locked
//   all_locked                        every enabled channel locked (at least one enabled)
//   lock_lost_sticky[N_CH]            a lock loss happened since last clear
//   relock_req      [N_CH]            one-cycle relock request after a lock timeout
//   loss_count      [N_CH*LOSS_CNT_W] saturating loss counters, channel i at [i*W +: W]
interface systempll_lock_monitor_if #(
  parameter int N_CH       = 4,
  parameter int LOSS_CNT_W = 8
);

  logic [N_CH-1:0]            in_synthlock;
  logic [N_CH-1:0]            disable_monitor;
  logic                       clear_sticky;
  logic [N_CH-1:0]            ch_locked;
  logic                       all_locked;
  logic [N_CH-1:0]            lock_lost_sticky;
  logic [N_CH-1:0]            relock_req;
  logic [N_CH*LOSS_CNT_W-1:0] loss_count;

  modport master (
    output in_synthlock, disable_monitor, clear_sticky,
    input  ch_locked, all_locked, lock_lost_sticky, relock_req, loss_count
  );

  modport slave (
    input  in_synthlock, disable_monitor, clear_sticky,
    output ch_locked, all_locked, lock_lost_sticky, relock_req, loss_count
  );

endinterface

// File: rtl/systempll_lock_ch.sv
// Supervision of one PLL channel: synchronizes the raw lock bit, runs the
// DISABLED / WAIT_LOCK / SETTLE / LOCKED state machine, raises relock requests
// on timeout and keeps the sticky loss flag and saturating loss counter.
//   clk, reset        clock, asynchronous active-high reset
//   synthlock_raw     raw lock bit (asynchronous)
//   disable_mon       supervision disable (synchronous)
//   clear_sticky      clear sticky flag and loss counter
//   locked            state is LOCKED
//   active            state is not DISABLED
//   lock_lost_sticky  sticky loss flag
//   relock_req        one-cycle timeout pulse
//   loss_count        saturating loss counter
module systempll_lock_ch
  import systempll_lock_monitor_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  synthlock_raw,
  input  logic                  disable_mon,
  input  logic                  clear_sticky,
  output logic                  locked,
  output logic                  active,
  output logic                  lock_lost_sticky,
  output logic                  relock_req,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]         SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX     = {LOSS_CNT_W{1'b1}};

  logic [1:0]            sync_q, sync_d;
  ch_state_e             state_q, state_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [TW-1:0]         timeout_q, timeout_d;
  logic                  relock_q, relock_d;
  logic                  sticky_q, sticky_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  slock_s;
  logic                  loss_event_s;

  assign slock_s = sync_q[1];

  // Next-state, counter and relock logic of the channel state machine.
  always_comb begin
    sync_d       = {sync_q[0], synthlock_raw};
    state_d      = state_q;
    settle_d     = settle_q;
    timeout_d    = timeout_q;
    loss_event_s = 1'b0;
    if (disable_mon) begin
      // Disable overrides everything; a LOCKED channel leaves without a loss.
      state_d   = CH_DISABLED;
      settle_d  = {SW{1'b0}};
      timeout_d = {TW{1'b0}};
    end else begin
      case (state_q)
        CH_DISABLED: begin
          state_d   = CH_WAIT_LOCK;
          settle_d  = {SW{1'b0}};
          timeout_d = {TW{1'b0}};
        end
        CH_WAIT_LOCK: begin
          if (slock_s) begin
            state_d   = CH_SETTLE;
            settle_d  = {SW{1'b0}};
            timeout_d = {TW{1'b0}};
          end else if (timeout_q == TIMEOUT_LAST) begin
            timeout_d = {TW{1'b0}};
          end else begin
            timeout_d = timeout_q + TW'(1'b1);
          end
        end
        CH_SETTLE: begin
          if (!slock_s) begin
            state_d   = CH_WAIT_LOCK;
            settle_d  = {SW{1'b0}};
            timeout_d = {TW{1'b0}};
          end else if (settle_q == SETTLE_LAST) begin
            state_d  = CH_LOCKED;
            settle_d = {SW{1'b0}};
          end else begin
            settle_d = settle_q + SW'(1'b1);
          end
        end
        CH_LOCKED: begin
          if (!slock_s) begin
            state_d      = CH_WAIT_LOCK;
            timeout_d    = {TW{1'b0}};
            loss_event_s = 1'b1;
          end else begin
            state_d = CH_LOCKED;
          end
        end
        default: begin
          state_d   = CH_WAIT_LOCK;
          settle_d  = {SW{1'b0}};
          timeout_d = {TW{1'b0}};
        end
      endcase
    end
    // The request flop is high exactly while the timeout counter sits at its
    // last value in WAIT_LOCK, so it is a one-cycle pulse per timeout period.
    relock_d = (state_d == CH_WAIT_LOCK) && (timeout_d == TIMEOUT_LAST);
  end

  // Sticky flag and loss counter; a loss on the clearing edge wins.
  always_comb begin
    sticky_d = sticky_q;
    loss_d   = loss_q;
    if (loss_event_s) begin
      sticky_d = 1'b1;
      if (clear_sticky) begin
        loss_d = LOSS_CNT_W'(1'b1);
      end else if (loss_q == LOSS_MAX) begin
        loss_d = loss_q;
      end else begin
        loss_d = loss_q + LOSS_CNT_W'(1'b1);
      end
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
      loss_d   = {LOSS_CNT_W{1'b0}};
    end else begin
      sticky_d = sticky_q;
      loss_d   = loss_q;
    end
  end

  // Channel state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b00;
      state_q   <= CH_WAIT_LOCK;
      settle_q  <= {SW{1'b0}};
      timeout_q <= {TW{1'b0}};
      relock_q  <= 1'b0;
      sticky_q  <= 1'b0;
      loss_q    <= {LOSS_CNT_W{1'b0}};
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      settle_q  <= settle_d;
      timeout_q <= timeout_d;
      relock_q  <= relock_d;
      sticky_q  <= sticky_d;
      loss_q    <= loss_d;
    end
  end

  assign locked           = (state_q == CH_LOCKED);
  assign active           = (state_q != CH_DISABLED);
  assign lock_lost_sticky = sticky_q;
  assign relock_req       = relock_q;
  assign loss_count       = loss_q;

endmodule

// File: rtl/systempll_lock_monitor.sv
// System PLL lock monitor: N_CH independent channel supervisors plus the
// aggregate all_locked flag.
//   clk, reset : sole clock, asynchronous active-high reset
//   bus        : slave side of systempll_lock_monitor_if; its N_CH and
//                LOSS_CNT_W must match this module's parameters
module systempll_lock_monitor
  import systempll_lock_monitor_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  systempll_lock_monitor_if.slave  bus
);

  logic [N_CH-1:0]            locked_s;
  logic [N_CH-1:0]            active_s;
  logic [N_CH-1:0]            sticky_s;
  logic [N_CH-1:0]            relock_s;
  logic [N_CH*LOSS_CNT_W-1:0] loss_s;
  logic                       all_locked_q, all_locked_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    systempll_lock_ch #(
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .LOSS_CNT_W     (LOSS_CNT_W)
    ) u_ch (
      .clk              (clk),
      .reset            (reset),
      .synthlock_raw    (bus.in_synthlock[i]),
      .disable_mon      (bus.disable_monitor[i]),
      .clear_sticky     (bus.clear_sticky),
      .locked           (locked_s[i]),
      .active           (active_s[i]),
      .lock_lost_sticky (sticky_s[i]),
      .relock_req       (relock_s[i]),
      .loss_count       (loss_s[i*LOSS_CNT_W +: LOSS_CNT_W])
    );
  end

  // All enabled channels locked, and at least one channel enabled.
  always_comb begin
    all_locked_d = (|active_s) && ((active_s & ~locked_s) == {N_CH{1'b0}});
  end

  // Aggregate flag register, one cycle behind the channel states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= all_locked_d;
    end
  end

  assign bus.ch_locked        = locked_s;
  assign bus.all_locked       = all_locked_q;
  assign bus.lock_lost_sticky = sticky_s;
  assign bus.relock_req       = relock_s;
  assign bus.loss_count       = loss_s;

endmodule

// File: tb/tb_systempll_lock_monitor.sv
module tb_systempll_lock_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  systempll_lock_monitor_if #(.N_CH(4), .LOSS_CNT_W(4)) bus();

  systempll_lock_monitor #(
    .N_CH(4), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(64), .LOSS_CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  lock;
    logic [3:0]  dis;
    logic        clr;
    int          hold;
    logic [3:0]  exp_locked;
    logic        exp_all;
    logic [3:0]  exp_sticky;
    logic [15:0] exp_loss;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];
  int   pulse_q[$];
  vec_t tbl[18];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic vec_t mk(string n, logic [3:0] lock, logic [3:0] dis, logic clr,
                              int hold, logic [3:0] el, logic ea, logic [3:0] es,
                              logic [15:0] eloss);
    vec_t v;
    v.name = n; v.lock = lock; v.dis = dis; v.clr = clr; v.hold = hold;
    v.exp_locked = el; v.exp_all = ea; v.exp_sticky = es; v.exp_loss = eloss;
    return v;
  endfunction

  // Drive one vector at a negedge, hold it for v.hold rising edges, then
  // compare against the expectation queued when it was driven.
  task automatic apply(input vec_t v);
    vec_t e;
    bus.in_synthlock    = v.lock;
    bus.disable_monitor = v.dis;
    bus.clear_sticky    = v.clr;
    exp_q.push_back(v);
    repeat (v.hold) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.name, ".ch_locked"},        bus.ch_locked,        e.exp_locked);
    chk({e.name, ".all_locked"},       bus.all_locked,       e.exp_all);
    chk({e.name, ".lock_lost_sticky"}, bus.lock_lost_sticky, e.exp_sticky);
    chk({e.name, ".loss_count"},       bus.loss_count,       e.exp_loss);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".ch_locked"},  bus.ch_locked,        4'h0);
    chk({name, ".all_locked"}, bus.all_locked,       1'b0);
    chk({name, ".sticky"},     bus.lock_lost_sticky, 4'h0);
    chk({name, ".loss"},       bus.loss_count,       16'h0000);
    chk({name, ".relock"},     bus.relock_req,       4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat;
    logic [3:0] exp_rl;

    tbl[0]  = mk("lock_pre",   4'hF, 4'h0, 1'b0, 10, 4'h0, 1'b0, 4'h0, 16'h0000);
    tbl[1]  = mk("lock_edge10",4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b0, 4'h0, 16'h0000);
    tbl[2]  = mk("all_edge11", 4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h0, 16'h0000);
    tbl[3]  = mk("ch2_drop_a", 4'hB, 4'h0, 1'b0,  2, 4'hF, 1'b1, 4'h0, 16'h0000);
    tbl[4]  = mk("ch2_drop_b", 4'hB, 4'h0, 1'b0,  1, 4'hB, 1'b1, 4'h4, 16'h0100);
    tbl[5]  = mk("ch2_drop_c", 4'hB, 4'h0, 1'b0,  1, 4'hB, 1'b0, 4'h4, 16'h0100);
    tbl[6]  = mk("ch2_rel_a",  4'hF, 4'h0, 1'b0, 10, 4'hB, 1'b0, 4'h4, 16'h0100);
    tbl[7]  = mk("ch2_rel_b",  4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b0, 4'h4, 16'h0100);
    tbl[8]  = mk("ch2_rel_c",  4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h4, 16'h0100);
    tbl[9]  = mk("clear",      4'hF, 4'h0, 1'b1,  1, 4'hF, 1'b1, 4'h0, 16'h0000);
    tbl[10] = mk("clear_hold", 4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h0, 16'h0000);
    tbl[11] = mk("dis3_a",     4'h7, 4'h8, 1'b0,  1, 4'h7, 1'b1, 4'h0, 16'h0000);
    tbl[12] = mk("dis3_b",     4'h7, 4'h8, 1'b0,  5, 4'h7, 1'b1, 4'h0, 16'h0000);
    tbl[13] = mk("disall_a",   4'h7, 4'hF, 1'b0,  1, 4'h0, 1'b1, 4'h0, 16'h0000);
    tbl[14] = mk("disall_b",   4'h7, 4'hF, 1'b0,  1, 4'h0, 1'b0, 4'h0, 16'h0000);
    tbl[15] = mk("reen_a",     4'hF, 4'h0, 1'b0, 10, 4'h7, 1'b0, 4'h0, 16'h0000);
    tbl[16] = mk("reen_b",     4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b0, 4'h0, 16'h0000);
    tbl[17] = mk("reen_c",     4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h0, 16'h0000);

    bus.in_synthlock    = 4'h0;
    bus.disable_monitor = 4'h0;
    bus.clear_sticky    = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // Channel 1 glitches low for one cycle while its settle count is 5.
    apply(mk("g_dis",      4'hD, 4'h2, 1'b0,  2, 4'hD, 1'b1, 4'h0, 16'h0000));
    apply(mk("g_pre",      4'hF, 4'h0, 1'b0,  6, 4'hD, 1'b0, 4'h0, 16'h0000));
    apply(mk("g_glitch",   4'hD, 4'h0, 1'b0,  1, 4'hD, 1'b0, 4'h0, 16'h0000));
    apply(mk("g_resettle", 4'hF, 4'h0, 1'b0, 10, 4'hD, 1'b0, 4'h0, 16'h0000));
    apply(mk("g_relock",   4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b0, 4'h0, 16'h0000));
    apply(mk("g_all",      4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h0, 16'h0000));

    // Channel 2 loses lock 20 times; counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      sat = (i + 1 > 15) ? 15 : i + 1;
      apply(mk($sformatf("sat_drop%0d", i), 4'hB, 4'h0, 1'b0, 3, 4'hB, 1'b1, 4'h4,
               16'(sat) << 8));
      apply(mk($sformatf("sat_rel%0d", i), 4'hF, 4'h0, 1'b0, 11, 4'hF, 1'b0, 4'h4,
               16'(sat) << 8));
    end
    apply(mk("sat_clear", 4'hF, 4'h0, 1'b1, 1, 4'hF, 1'b1, 4'h0, 16'h0000));
    apply(mk("sat_hold",  4'hF, 4'h0, 1'b0, 1, 4'hF, 1'b1, 4'h0, 16'h0000));

    // Clear on the same edge as a channel 0 loss: the loss wins.
    apply(mk("c0_pre",   4'hE, 4'h0, 1'b0,  2, 4'hF, 1'b1, 4'h0, 16'h0000));
    apply(mk("c0_clr",   4'hE, 4'h0, 1'b1,  1, 4'hE, 1'b1, 4'h1, 16'h0001));
    apply(mk("c0_after", 4'hE, 4'h0, 1'b0,  1, 4'hE, 1'b0, 4'h1, 16'h0001));
    apply(mk("c0_rel",   4'hF, 4'h0, 1'b0, 11, 4'hF, 1'b0, 4'h1, 16'h0001));
    apply(mk("c0_all",   4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h1, 16'h0001));

    // Reset while locked, then reset again mid-settle: progress is discarded.
    reset = 1'b1;
    #1;
    chk_reset_state("rst_locked");
    @(negedge clk);
    reset = 1'b0;
    apply(mk("rst_part", 4'hF, 4'h0, 1'b0, 5, 4'h0, 1'b0, 4'h0, 16'h0000));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(mk("rst_settle", 4'hF, 4'h0, 1'b0, 10, 4'h0, 1'b0, 4'h0, 16'h0000));
    apply(mk("rst_lock",   4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b0, 4'h0, 16'h0000));
    apply(mk("rst_all",    4'hF, 4'h0, 1'b0,  1, 4'hF, 1'b1, 4'h0, 16'h0000));

    // Channel 3 without lock: relock pulses 63, 127, 191 cycles after entry.
    apply(mk("rl_dis", 4'h7, 4'h8, 1'b0, 1, 4'h7, 1'b1, 4'h0, 16'h0000));
    bus.disable_monitor = 4'h0;
    pulse_q.push_back(63);
    pulse_q.push_back(127);
    pulse_q.push_back(191);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_rl = 4'h0;
      if (pulse_q.size() > 0 && pulse_q[0] == i) begin
        exp_rl = 4'h8;
        void'(pulse_q.pop_front());
      end
      chk($sformatf("relock_c%0d", i), bus.relock_req, exp_rl);
    end
    chk("relock_pulses_left", pulse_q.size(), 0);
    chk("relock_locked", bus.ch_locked, 4'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systempll_lock_monitor.md
SYSTEMPLL_LOCK_MONITOR -- requirements
Module: systempll_lock_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of system PLL channels supervised.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 256, meaning consecutive synced-lock cycles required before a channel is declared locked (range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536, meaning cycles without lock before a relock request (range 2..2^24).
REQ-004 SHALL have parameter LOSS_CNT_W, default 8, meaning width of each per-channel loss counter.
REQ-005 SHALL have ports clk, in, 1, sole clock; reset, in, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_synthlock, in, N_CH, raw per-channel PLL synthlock (asynchronous to clk).
REQ-007 SHALL have port disable_monitor, in, N_CH, per-channel monitor disable (synchronous to clk).
REQ-008 SHALL have port clear_sticky, in, 1, one-cycle clear of sticky flags and loss counters.
REQ-009 SHALL have ports ch_locked, out, N_CH; all_locked, out, 1; lock_lost_sticky, out, N_CH; relock_req, out, N_CH (one-cycle pulses); loss_count, out, N_CH*LOSS_CNT_W (channel i at bits [i*LOSS_CNT_W +: LOSS_CNT_W]).

Function
REQ-010 Each in_synthlock bit SHALL pass through a 2-flop synchronizer before use; the synced value is "slock".
REQ-011 Each channel SHALL run an independent FSM with states DISABLED, WAIT_LOCK, SETTLE, LOCKED.
REQ-012 Any state: disable_monitor[i]=1 -> DISABLED next edge, counters cleared; DISABLED with disable_monitor[i]=0 -> WAIT_LOCK.
REQ-013 WAIT_LOCK: slock=1 -> SETTLE with settle counter 0; else timeout counter increments.
REQ-014 WAIT_LOCK: when timeout counter reaches TIMEOUT_CYCLES-1, relock_req[i] SHALL pulse high one cycle, timeout counter wraps to 0, state stays WAIT_LOCK.
REQ-015 SETTLE: slock=0 -> WAIT_LOCK (timeout counter 0); settle counter = SETTLE_CYCLES-1 with slock=1 -> LOCKED; else counter increments.
REQ-016 LOCKED: slock=0 -> WAIT_LOCK on the next edge; same edge sets lock_lost_sticky[i] and increments loss_count[i], saturating at 2^LOSS_CNT_W-1.
REQ-017 ch_locked[i] SHALL equal (state==LOCKED), decoded from the state register without extra delay.
REQ-018 Latency: in_synthlock rising before edge k and held -> ch_locked high after edge k+2+SETTLE_CYCLES; falling before edge j -> ch_locked low after edge j+2.
REQ-019 all_locked SHALL be 1 iff at least one channel is not DISABLED and every non-DISABLED channel is LOCKED; registered, one cycle behind ch_locked.
REQ-020 clear_sticky SHALL zero all lock_lost_sticky and loss_count on the next edge; a loss event on the same edge wins (sticky=1, count=1).
REQ-021 Disabling a LOCKED channel SHALL NOT count as a loss.
REQ-022 relock_req SHALL never be asserted in DISABLED, SETTLE or LOCKED.

Reset
REQ-023 reset SHALL asynchronously force: synchronizers 0, all FSMs to WAIT_LOCK (DISABLED on first edge if disabled), counters 0, ch_locked 0, all_locked 0, lock_lost_sticky 0, loss_count 0, relock_req 0.
REQ-024 Reset mid-SETTLE or mid-LOCKED SHALL discard progress; no sticky or loss increment from reset itself.

Structure
REQ-025 Shared package SHALL hold the channel state enum (2 bits) and counter-width helper function (clog2-based).
REQ-026 Per-channel logic SHALL live in one sub-module, systempll_lock_ch, instantiated N_CH times via generate; top holds all_locked and output packing.

Verification (N_CH=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=64, LOSS_CNT_W=4)
REQ-027 Reset release, in_synthlock=4'hF before edge 0 -> ch_locked=4'hF after edge 10, all_locked=1 after edge 11.
REQ-028 Ch1 lock glitches low 1 cycle at settle count 5 -> ch1 back to WAIT_LOCK, ch_locked[1] rises 8 cycles after re-sync, no sticky.
REQ-029 Ch2 locked, drop lock 20 times -> lock_lost_sticky[2]=1, loss_count[2]=15 (saturated); clear_sticky -> both 0.
REQ-030 Ch3 in_synthlock held 0 for 200 cycles -> relock_req[3] pulses at cycles 63, 127, 191 after entering WAIT_LOCK, each 1 cycle wide.
REQ-031 disable_monitor=4'b1000 while ch3 unlocked, others locked -> all_locked=1; disable_monitor=4'hF -> all_locked=0, no sticky set.
REQ-032 clear_sticky on same edge as ch0 loss -> lock_lost_sticky[0]=1, loss_count[0]=1.
